// File: rtl/vpu_dst_port_if.sv
// Bundle of the vpu_dst_port control, VLANE result and SRAM write signals.
// The slave side belongs to vpu_dst_port; the master side is the surrounding system.
interface vpu_dst_port_if #(
    parameter int SRAM_DATA_WIDTH = 512,
    parameter int DWIDTH_PER_EXEC = 256,
    parameter int SRAM_ADDR_WIDTH = 10
);
    logic                       start_i;
    logic                       wvalid_i;
    logic [SRAM_ADDR_WIDTH-1:0] waddr_i;
    logic                       done_o;
    logic                       result_wren_i;
    logic [DWIDTH_PER_EXEC-1:0] result_wdata_i;
    logic                       result_ready_o;
    logic                       sram_wr_req_o;
    logic [SRAM_ADDR_WIDTH-1:0] sram_wr_addr_o;
    logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_o;
    logic                       sram_wr_gnt_i;

    modport master (
        output start_i, wvalid_i, waddr_i, result_wren_i, result_wdata_i, sram_wr_gnt_i,
        input  done_o, result_ready_o, sram_wr_req_o, sram_wr_addr_o, sram_wr_data_o
    );

    modport slave (
        input  start_i, wvalid_i, waddr_i, result_wren_i, result_wdata_i, sram_wr_gnt_i,
        output done_o, result_ready_o, sram_wr_req_o, sram_wr_addr_o, sram_wr_data_o
    );
endinterface

// File: rtl/vpu_dst_port.sv
// Packs EXEC_CNT VLANE result slices into one SRAM line, issues a single
// write to the decoded destination address, then pulses done to the controller.
module vpu_dst_port #(
    parameter int SRAM_DATA_WIDTH = 512,
    parameter int DWIDTH_PER_EXEC = 256,
    parameter int EXEC_CNT        = SRAM_DATA_WIDTH / DWIDTH_PER_EXEC,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input logic              clk,
    input logic              rst_n,
    vpu_dst_port_if.slave    dst_if
);
    localparam int                CNT_W    = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SRAM_DATA_WIDTH-1:0] line_buf_q, line_buf_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_buf_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_buf_q <= line_buf_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_buf_d = line_buf_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (dst_if.start_i) begin
                    if (dst_if.wvalid_i) begin
                        addr_d  = dst_if.waddr_i;
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COLLECT: begin
                if (dst_if.result_wren_i) begin
                    // Slice 0 lands in the LSBs of the line.
                    line_buf_d[int'(cnt_q)*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = dst_if.result_wdata_i;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (dst_if.sram_wr_gnt_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so an async reset drops a pending request at once.
    assign dst_if.done_o         = (state_q == DONE);
    assign dst_if.result_ready_o = (state_q == COLLECT);
    assign dst_if.sram_wr_req_o  = (state_q == WRITE);
    assign dst_if.sram_wr_addr_o = addr_q;
    assign dst_if.sram_wr_data_o = line_buf_q;
endmodule

// File: tb/tb_vpu_dst_port.sv
// Scoreboard bench for vpu_dst_port: stimulus queues expected writes and done
// cycles, a negedge monitor compares whatever the DUT presents.
module tb_vpu_dst_port;
    localparam int SW = 512;
    localparam int DW = 256;
    localparam int AW = 10;
    localparam int EC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [AW-1:0] exp_addr[$];
    logic [SW-1:0] exp_data[$];
    int            exp_done[$];

    logic [DW-1:0] s1  = {32{8'h11}};
    logic [DW-1:0] s2  = {32{8'h22}};
    logic [DW-1:0] s3  = {32{8'hA3}};
    logic [DW-1:0] s4  = {32{8'h4C}};
    logic [DW-1:0] s5  = {16{16'h5A5A}};
    logic [DW-1:0] s6  = {16{16'h6006}};
    logic [DW-1:0] s7  = {32{8'h77}};
    logic [DW-1:0] s8  = {32{8'h88}};
    logic [DW-1:0] s9  = {8{32'h9ABC_DEF0}};
    logic [DW-1:0] s10 = {8{32'h1234_5678}};
    logic [DW-1:0] junk = {32{8'hEE}};

    vpu_dst_port_if #(
        .SRAM_DATA_WIDTH(SW),
        .DWIDTH_PER_EXEC(DW),
        .SRAM_ADDR_WIDTH(AW)
    ) bus ();

    vpu_dst_port #(
        .SRAM_DATA_WIDTH(SW),
        .DWIDTH_PER_EXEC(DW),
        .EXEC_CNT(EC),
        .SRAM_ADDR_WIDTH(AW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dst_if(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented request is compared to the queue head; a grant retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sram_wr_req_o) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected got=req exp=none cyc=%0d", cyc);
                end else begin
                    check("wr_addr", SW'(bus.sram_wr_addr_o), SW'(exp_addr[0]));
                    check("wr_data", bus.sram_wr_data_o, exp_data[0]);
                    if (bus.sram_wr_gnt_i) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
            end
            if (bus.done_o) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected got=1 exp=0 cyc=%0d", cyc);
                end else begin
                    check("done_cycle", SW'(cyc), SW'(exp_done.pop_front()));
                end
            end
        end
    end

    initial begin
        int t;
        bus.start_i        = 1'b0;
        bus.wvalid_i       = 1'b0;
        bus.waddr_i        = '0;
        bus.result_wren_i  = 1'b0;
        bus.result_wdata_i = '0;
        bus.sram_wr_gnt_i  = 1'b0;

        // Reset state, then idle with no activity.
        repeat (2) step();
        check("rst_done",  SW'(bus.done_o), '0);
        check("rst_ready", SW'(bus.result_ready_o), '0);
        check("rst_req",   SW'(bus.sram_wr_req_o), '0);
        check("rst_addr",  SW'(bus.sram_wr_addr_o), '0);
        check("rst_data",  bus.sram_wr_data_o, '0);
        rst_n = 1'b1;
        repeat (5) step();

        // Basic back-to-back write with grant tied high.
        bus.sram_wr_gnt_i = 1'b1;
        step();
        t = cyc;
        bus.start_i = 1'b1; bus.wvalid_i = 1'b1; bus.waddr_i = 10'h005;
        exp_addr.push_back(10'h005); exp_data.push_back({s2, s1}); exp_done.push_back(t + 4);
        step();
        bus.start_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s1;
        @(negedge clk);
        check("ready_collect", SW'(bus.result_ready_o), SW'(1));
        step();
        bus.result_wdata_i = s2;
        step();
        bus.result_wren_i = 1'b0;
        @(negedge clk);
        check("req_rise", SW'(bus.sram_wr_req_o), SW'(1));
        check("ready_write", SW'(bus.result_ready_o), '0);
        repeat (3) step();

        // Gapped slices with a four-cycle grant stall.
        bus.sram_wr_gnt_i = 1'b0;
        t = cyc + 1;
        step();
        bus.start_i = 1'b1; bus.wvalid_i = 1'b1; bus.waddr_i = 10'h0A0;
        exp_addr.push_back(10'h0A0); exp_data.push_back({s4, s3}); exp_done.push_back(t + 11);
        step();
        bus.start_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s3;
        step();
        bus.result_wren_i = 1'b0;
        repeat (3) step();
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s4;
        step();
        bus.result_wren_i = 1'b0;
        repeat (4) step();
        bus.sram_wr_gnt_i = 1'b1;
        step();
        bus.sram_wr_gnt_i = 1'b0;
        repeat (3) step();

        // No destination operand: done next cycle, no SRAM access.
        step();
        bus.start_i = 1'b1; bus.wvalid_i = 1'b0;
        exp_done.push_back(cyc + 1);
        step();
        bus.start_i = 1'b0;
        repeat (3) step();

        // Stray slice in IDLE and a second start during COLLECT are both ignored.
        bus.sram_wr_gnt_i = 1'b1;
        step();
        bus.result_wren_i = 1'b1; bus.result_wdata_i = junk;
        step();
        bus.result_wren_i = 1'b0;
        bus.start_i = 1'b1; bus.wvalid_i = 1'b1; bus.waddr_i = 10'h123;
        exp_addr.push_back(10'h123); exp_data.push_back({s6, s5}); exp_done.push_back(cyc + 4);
        step();
        bus.waddr_i = 10'h2AA;
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s5;
        step();
        bus.start_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.result_wdata_i = s6;
        step();
        bus.result_wren_i = 1'b0;
        repeat (3) step();

        // Reset while a write request is pending, then a fresh instruction.
        bus.sram_wr_gnt_i = 1'b0;
        step();
        bus.start_i = 1'b1; bus.wvalid_i = 1'b1; bus.waddr_i = 10'h055;
        exp_addr.push_back(10'h055); exp_data.push_back({s8, s7});
        step();
        bus.start_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s7;
        step();
        bus.result_wdata_i = s8;
        step();
        bus.result_wren_i = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req",   SW'(bus.sram_wr_req_o), '0);
        check("abort_done",  SW'(bus.done_o), '0);
        check("abort_ready", SW'(bus.result_ready_o), '0);
        check("abort_addr",  SW'(bus.sram_wr_addr_o), '0);
        check("abort_data",  bus.sram_wr_data_o, '0);
        exp_addr.delete();
        exp_data.delete();
        step();
        step();
        rst_n = 1'b1;
        bus.sram_wr_gnt_i = 1'b1;
        step();
        bus.start_i = 1'b1; bus.wvalid_i = 1'b1; bus.waddr_i = 10'h3FF;
        exp_addr.push_back(10'h3FF); exp_data.push_back({s10, s9}); exp_done.push_back(cyc + 4);
        step();
        bus.start_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.result_wren_i = 1'b1; bus.result_wdata_i = s9;
        step();
        bus.result_wdata_i = s10;
        step();
        bus.result_wren_i = 1'b0;
        repeat (4) step();

        // Every queued write and done must have been observed.
        check("wr_outstanding",   SW'(exp_addr.size()), '0);
        check("done_outstanding", SW'(exp_done.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vpu_dst_port.md
# vpu_dst_port

- Write-side counterpart of the VPU source port.
- Collects per-execution result slices from the VLANE (DWIDTH_PER_EXEC bits each, EXEC_CNT slices per instruction) and packs them into one SRAM line.
- Issues a single SRAM write to the decoded destination address and signals completion to VPU_CONTROLLER.
- Sits between the VLANE result output and the SRAM write port.

## Interface
Parameters:
- SRAM_DATA_WIDTH, 512, SRAM line width in bits
- DWIDTH_PER_EXEC, 256, result slice width per execution cycle
- EXEC_CNT, SRAM_DATA_WIDTH/DWIDTH_PER_EXEC (2), slices per line; must be ≥1 and an exact divisor relation
- SRAM_ADDR_WIDTH, 10, SRAM line address width

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  one-cycle instruction start pulse from VPU_CONTROLLER
- wvalid_i  in  1  decoded instruction has a destination operand
- waddr_i  in  SRAM_ADDR_WIDTH  decoded destination line address
- done_o  out  1  one-cycle completion pulse to VPU_CONTROLLER
- result_wren_i  in  1  VLANE result slice valid
- result_wdata_i  in  DWIDTH_PER_EXEC  VLANE result slice
- result_ready_o  out  1  block accepts a slice this cycle
- sram_wr_req_o  out  1  SRAM write request
- sram_wr_addr_o  out  SRAM_ADDR_WIDTH  SRAM write address
- sram_wr_data_o  out  SRAM_DATA_WIDTH  SRAM write data
- sram_wr_gnt_i  in  1  SRAM write grant; the write is accepted on a cycle where req and gnt are both high

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start_i & wvalid_i: latch waddr_i, clear slice counter cnt, go to COLLECT.
  - start_i & !wvalid_i: go to DONE directly; no SRAM access.
  - result_wren_i is ignored; result_ready_o=0.
- COLLECT:
  - result_ready_o=1.
  - On result_wren_i: write result_wdata_i into line_buf[cnt*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC]. Slice 0 is the LSBs.
  - If cnt==EXEC_CNT-1, cnt wraps to 0 and the FSM goes to WRITE. Otherwise cnt increments.
  - Cycles without result_wren_i hold all state.
- WRITE:
  - sram_wr_req_o=1; sram_wr_addr_o = latched address; sram_wr_data_o = line_buf.
  - Request, address and data stay stable until grant.
  - On sram_wr_gnt_i, go to DONE. result_ready_o=0.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- start_i outside IDLE is ignored; no queuing.
- sram_wr_gnt_i without sram_wr_req_o has no effect.
- When sram_wr_req_o=0, sram_wr_addr_o and sram_wr_data_o carry the registered values and are don't-care to the SRAM.
- cnt width is max(1,$clog2(EXEC_CNT)). It never reaches EXEC_CNT; the wrap condition is explicit.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths except none.
- Reset values: state=IDLE, cnt=0, line_buf=0, latched address=0, done_o=0, result_ready_o=0, sram_wr_req_o=0, sram_wr_addr_o=0, sram_wr_data_o=0.
- Reset asserted mid-operation (any state) immediately returns to reset values. A pending SRAM request drops asynchronously. Collected slices are discarded.
- Cycle T: start_i with wvalid_i=1. T+1: COLLECT, result_ready_o=1.
- With back-to-back slices at T+1..T+EXEC_CNT: sram_wr_req_o rises at T+EXEC_CNT+1.
- Grant in the same cycle as request at cycle W: done_o=1 at W+1.
- Minimum latency from start to done with wvalid_i=1 and immediate grant: EXEC_CNT+2 cycles.
- start_i with wvalid_i=0 at T: done_o=1 at T+1.
- A slice presented in the cycle the last slice is accepted cannot occur, because the FSM leaves COLLECT. A slice presented in WRITE is not accepted (ready=0); the VLANE must hold it.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, state IDLE. Release, then idle for 5 cycles -> no req, no done.
- Basic write: start with waddr=0x05 and slices 0x1111…, 0x2222… back-to-back, grant tied high -> one req with addr 0x05 and data {0x2222…,0x1111…}; done_o 4 cycles after start; single done pulse.
- Gapped slices plus stalled grant: 3 idle cycles between slices, gnt low for 4 cycles -> data is unchanged over the stall, req is held with stable addr/data, exactly one accepted write, done the cycle after grant.
- No destination: start with wvalid_i=0 -> done_o=1 at T+1, sram_wr_req_o never asserts.
- Ignored events: result_wren_i in IDLE and a second start_i during COLLECT -> the stray slice is not captured, the latched address is unchanged, and the write uses the original address and data.
- Reset mid-WRITE: assert rst_n while req=1 -> req drops immediately. A following instruction (waddr=0x3FF, new slices) writes only the new data, with no residue from the aborted instruction.
